mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 143 ++++++++++++++
 tb/tb_mem_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
//==============================================================================
// Module  : mem_responder
// Brief   : Single-port word memory responder with fixed-latency responses,
//           byte-lane writes, masked reads and address/byte-enable error checks.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_responder #(
  parameter int LATENCY    = 2,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic        gnt,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic                    we_q;
  logic [31:0]             addr_q;
  logic [3:0]              be_q;
  logic [31:0]             wdata_q;
  logic                    rvalid_q;
  logic                    err_q;
  logic [31:0]             rdata_q;
  logic [31:0]             mem_q [WORDS];

  logic [DEPTH_LOG2-1:0]   idx_w;
  logic [31:0]             mask_w;
  logic                    be_ok_w;
  logic                    range_ok_w;
  logic                    acc_ok_w;
  logic                    resp_enter_w;
  logic [31:0]             rdata_d;
  logic                    err_d;

  assign gnt = req && reset && (state_q == IDLE);

  assign idx_w        = addr_q[DEPTH_LOG2+1:2];
  assign range_ok_w   = ((addr_q >> (DEPTH_LOG2 + 2)) == 32'd0);
  assign mask_w       = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
  assign acc_ok_w     = be_ok_w && range_ok_w;
  assign resp_enter_w = (state_q == WAIT) && (cnt_q == 4'd0);

  // Only naturally aligned bytes, halves and full words are accepted.
  always_comb begin
    be_ok_w = 1'b0;
    case (be_q)
      4'b1111, 4'b0011, 4'b1100,
      4'b0001, 4'b0010, 4'b0100, 4'b1000: be_ok_w = 1'b1;
      default:                            be_ok_w = 1'b0;
    endcase
  end

  always_comb begin
    rdata_d = 32'd0;
    err_d   = !acc_ok_w;
    if (acc_ok_w && !we_q) begin
      rdata_d = mem_q[idx_w] & mask_w;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      be_q     <= 4'd0;
      wdata_q  <= 32'd0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          rvalid_q <= 1'b0;
          if (gnt) begin
            we_q    <= we;
            addr_q  <= addr;
            be_q    <= be;
            wdata_q <= wdata;
            cnt_q   <= 4'(LATENCY - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q  <= RESP;
            rvalid_q <= 1'b1;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          rvalid_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          rvalid_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  // Storage commits on the same edge that launches the response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WORDS; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (resp_enter_w && we_q && acc_ok_w) begin
      mem_q[idx_w] <= (mem_q[idx_w] & ~mask_w) | (wdata_q & mask_w);
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// Directed bench: three responders (LATENCY 2, 1, 15) sharing the request bus.
`default_nettype none

module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic [2:0]  req_v;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [2:0]  gnt_v;
  logic [2:0]  rvalid_v;
  logic [2:0]  err_v;
  logic [31:0] rdata_v [3];

  int total;
  int bad;

  mem_responder #(.LATENCY(2), .DEPTH_LOG2(10)) u_dut0 (
    .clk(clk), .reset(reset), .req(req_v[0]), .we(we), .addr(addr), .be(be),
    .wdata(wdata), .gnt(gnt_v[0]), .rvalid(rvalid_v[0]), .rdata(rdata_v[0]), .err(err_v[0]));
  mem_responder #(.LATENCY(1), .DEPTH_LOG2(10)) u_dut1 (
    .clk(clk), .reset(reset), .req(req_v[1]), .we(we), .addr(addr), .be(be),
    .wdata(wdata), .gnt(gnt_v[1]), .rvalid(rvalid_v[1]), .rdata(rdata_v[1]), .err(err_v[1]));
  mem_responder #(.LATENCY(15), .DEPTH_LOG2(10)) u_dut2 (
    .clk(clk), .reset(reset), .req(req_v[2]), .we(we), .addr(addr), .be(be),
    .wdata(wdata), .gnt(gnt_v[2]), .rvalid(rvalid_v[2]), .rdata(rdata_v[2]), .err(err_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request on responder i; returns response data, error and grant-to-rvalid edges.
  task automatic txn(input int i, input logic w, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] d, output logic [31:0] rd, output logic e, output int lat);
    int n;
    @(negedge clk);
    we = w; addr = a; be = b; wdata = d; req_v[i] = 1'b1;
    #1;
    n = 0;
    while (!gnt_v[i] && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("gnt_seen", 32'(gnt_v[i]), 32'd1);
    @(posedge clk); #1;
    req_v[i] = 1'b0;
    lat = 0;
    while (!rvalid_v[i] && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    rd = rdata_v[i];
    e  = err_v[i];
    @(posedge clk); #1;
    check("rvalid_one_cycle", 32'(rvalid_v[i]), 32'd0);
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat;

  initial begin
    int grants, last, rv_cnt;
    logic granted;
    logic seen;
    total = 0; bad = 0;
    reset = 1'b0; req_v = 3'b001; we = 1'b0; addr = 32'd0; be = 4'hF; wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(gnt_v[0]), 32'd0);
    check("rst_rvalid", 32'(rvalid_v[0]), 32'd0);
    check("rst_rdata", rdata_v[0], 32'd0);
    check("rst_err", 32'(err_v[0]), 32'd0);
    req_v = 3'b000;
    reset = 1'b1;

    // Full word write then read
    txn(0, 1'b1, 32'h10, 4'b1111, 32'h1234_5678, rd, e, lat);
    check("wr_lat", 32'(lat), 32'd2);
    check("wr_rdata", rd, 32'd0);
    check("wr_err", 32'(e), 32'd0);
    txn(0, 1'b0, 32'h10, 4'b1111, 32'h0, rd, e, lat);
    check("rd_lat", 32'(lat), 32'd2);
    check("rd_data", rd, 32'h1234_5678);
    check("rd_err", 32'(e), 32'd0);
    repeat (3) @(negedge clk);
    check("rdata_hold", rdata_v[0], 32'h1234_5678);

    // Byte and half lanes
    txn(0, 1'b1, 32'h10, 4'b0100, 32'h00AB_0000, rd, e, lat);
    txn(0, 1'b1, 32'h10, 4'b0011, 32'h0000_CDEF, rd, e, lat);
    txn(0, 1'b0, 32'h10, 4'b1111, 32'h0, rd, e, lat);
    check("lane_full", rd, 32'h12AB_CDEF);
    txn(0, 1'b0, 32'h10, 4'b1100, 32'h0, rd, e, lat);
    check("lane_hi_half", rd, 32'h12AB_0000);
    txn(0, 1'b0, 32'h13, 4'b0010, 32'h0, rd, e, lat);
    check("lane_byte1_unaligned", rd, 32'h0000_CD00);

    // Errors
    txn(0, 1'b1, 32'h1000, 4'b1111, 32'hDEAD_BEEF, rd, e, lat);
    check("oor_err", 32'(e), 32'd1);
    check("oor_rdata", rd, 32'd0);
    txn(0, 1'b0, 32'h0, 4'b1111, 32'h0, rd, e, lat);
    check("oor_no_alias_write", rd, 32'd0);
    txn(0, 1'b1, 32'h10, 4'b0101, 32'hFFFF_FFFF, rd, e, lat);
    check("be0101_err", 32'(e), 32'd1);
    txn(0, 1'b0, 32'h10, 4'b0000, 32'h0, rd, e, lat);
    check("be0000_err", 32'(e), 32'd1);
    check("be0000_rdata", rd, 32'd0);
    txn(0, 1'b0, 32'h10, 4'b1111, 32'h0, rd, e, lat);
    check("err_no_update", rd, 32'h12AB_CDEF);
    check("err_cleared", 32'(e), 32'd0);

    // Busy: req held high, three distinct writes
    @(negedge clk);
    we = 1'b1; be = 4'hF; addr = 32'h100; wdata = 32'hA0; req_v[0] = 1'b1;
    grants = 0; last = 0; rv_cnt = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      granted = gnt_v[0];
      if (granted) begin
        if (grants > 0) check("busy_gap", 32'(cyc - last), 32'd4);
        last = cyc;
        grants++;
      end
      if (rvalid_v[0]) rv_cnt++;
      @(posedge clk); #1;
      if (granted) begin
        if (grants == 3) req_v[0] = 1'b0;
        else begin
          addr  = addr + 32'd4;
          wdata = wdata + 32'd1;
        end
      end
      @(negedge clk);
    end
    req_v[0] = 1'b0;
    check("busy_grants", 32'(grants), 32'd3);
    check("busy_rvalids", 32'(rv_cnt), 32'd3);
    for (int k = 0; k < 3; k++) begin
      txn(0, 1'b0, 32'h100 + 32'(4 * k), 4'hF, 32'h0, rd, e, lat);
      check("busy_readback", rd, 32'hA0 + 32'(k));
    end

    // Reset one cycle after grant aborts the write
    @(negedge clk);
    we = 1'b1; addr = 32'h20; be = 4'hF; wdata = 32'hFFFF_FFFF; req_v[0] = 1'b1;
    #1;
    check("midrst_gnt", 32'(gnt_v[0]), 32'd1);
    @(posedge clk); #1;
    req_v[0] = 1'b0;
    seen = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    req_v[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rvalid_v[0]) seen = 1'b1;
    end
    check("midrst_gnt_low", 32'(gnt_v[0]), 32'd0);
    req_v[0] = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (rvalid_v[0]) seen = 1'b1;
    end
    check("midrst_no_rvalid", 32'(seen), 32'd0);
    txn(0, 1'b0, 32'h20, 4'hF, 32'h0, rd, e, lat);
    check("midrst_data", rd, 32'd0);
    txn(0, 1'b0, 32'h10, 4'hF, 32'h0, rd, e, lat);
    check("midrst_cleared_mem", rd, 32'd0);

    // Latency sweep
    txn(1, 1'b1, 32'h10, 4'hF, 32'h1234_5678, rd, e, lat);
    check("l1_wr_lat", 32'(lat), 32'd1);
    txn(1, 1'b0, 32'h10, 4'hF, 32'h0, rd, e, lat);
    check("l1_rd_lat", 32'(lat), 32'd1);
    check("l1_rd_data", rd, 32'h1234_5678);
    txn(2, 1'b1, 32'h10, 4'hF, 32'h1234_5678, rd, e, lat);
    check("l15_wr_lat", 32'(lat), 32'd15);
    txn(2, 1'b0, 32'h10, 4'hF, 32'h0, rd, e, lat);
    check("l15_rd_lat", 32'(lat), 32'd15);
    check("l15_rd_data", rd, 32'h1234_5678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
